alu_writeback: RTL
==================

Name: alu_writeback

Overview:
Commit stage directly downstream of the 8-bit ALU. It accepts one ALU result per cycle with its decode side-band (op select, destination register, branch target) over a valid/ready handshake. It holds the result in a one-deep buffer and writes it to the register-file write port, which has a wait handshake. It also maintains the committed PC, the sticky overflow status and a saturating overflow counter, and squashes wrong-path results after a taken branch.

Parameters:
DW, 8, datapath width (ALU result, register data)
AW, 3, register-file address width
PCW, 8, program-counter width
SQUASH_N, 2, number of accepted ops discarded after a taken branch (1..7)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept this cycle
in_sel  input  3  ALU op select of this result (0 add, 1 not, 2 and, 3 or, 4 sra, 5 sll, 6 beq, 7 bneq)
in_rd  input  AW  destination register
in_f  input  DW  ALU result
in_ovf  input  1  ALU overflow flag
in_take_branch  input  1  ALU branch decision
in_br_target  input  PCW  branch target PC
rf_we  output  1  register write request
rf_waddr  output  AW  write address
rf_wdata  output  DW  write data
rf_wready  input  1  register file accepts the write this cycle
pc  output  PCW  committed PC
flush  output  1  one-cycle redirect pulse to fetch
ovf_sticky  output  1  sticky overflow status
ovf_count  output  8  saturating overflow event count
clr_ovf  input  1  clears ovf_sticky and ovf_count

Behaviour:
- The clock is clk. Reset is rst_n: asynchronous, active-low.
- Reset values: in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, pc=0, flush=0, ovf_sticky=0, ovf_count=0. Squash counter=0.
- Reset mid-operation drops any buffered write with no partial write.
- Accept: acc = in_valid & in_ready.
- in_ready = ~rf_we | rf_wready. The buffer is one deep and full-throughput: a write can drain and a new one load in the same cycle.
- Squash: if the squash counter is nonzero at acceptance, the op is dropped and the counter decrements. A dropped op causes no write, no PC change, no flag update and no flush.
- Non-squashed accept, write class: in_sel 0..5 with in_rd != 0. At the accept edge, load rf_waddr=in_rd and rf_wdata=in_f, and set rf_we=1.
- rf_we holds with stable address and data until an edge where rf_wready=1. It then clears, unless a new write loads on the same edge.
- Writes to r0 and branch ops (sel 6/7) never assert rf_we.
- PC update on non-squashed accept:
  - sel 6/7 with in_take_branch=1: pc <= in_br_target. Next cycle flush=1 for exactly one cycle, and the squash counter loads SQUASH_N.
  - Otherwise: pc <= pc+1, modulo 2^PCW (wraps 255 to 0).
- Overflow: in_ovf counts only when in_sel==0 and the op is non-squashed and accepted. A counted overflow sets ovf_sticky, and ovf_count increments and saturates at 255.
- clr_ovf clears ovf_sticky and ovf_count at the edge. If clr_ovf and a counted overflow hit the same edge, the result is ovf_sticky=1 and ovf_count=1 (set wins).
- A taken branch accepted while the squash counter is nonzero is itself squashed. It does not reload the counter or flush.
- Latency: accept edge T. rf_we visible in cycle T+1. Earliest register write completes at edge T+1 if rf_wready=1.
- in_valid may drop without an accept, and upstream holds its data until accepted. The stage registers nothing for a cycle with no accept.

Test Plan:
- Add 0x70+0x20 result in_f=0x90, in_ovf=1, rd=3, rf_wready=1 -> rf_we=1 next cycle with waddr=3, wdata=0x90; ovf_sticky=1, ovf_count=1, pc 0->1.
- rf_wready=0 for 3 cycles with a second op pending -> in_ready=0, rf_we/waddr/wdata stable. When rf_wready=1, the second op loads on the drain edge with no bubble.
- BEQ with take_branch=1, target=0x40, then three ALU ops rd=1,2,4 -> pc=0x40, flush pulses one cycle. The first two ops are dropped (no rf_we); rd=4 is written and pc=0x41.
- Write to rd=0, plus BNEQ not taken -> no rf_we for either; pc increments twice.
- pc=0xFF, non-branch accept -> pc=0x00. 256 overflow adds -> ovf_count stays 255. clr_ovf coincident with an overflow -> count=1, sticky=1.
- Assert rst_n=0 asynchronously while rf_we=1 and squash=2 -> all outputs are reset values immediately. After release, the next op is not squashed.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Handshake bundle between the ALU, this commit stage and the register-file write port.
// Upstream drives the in_* side band and the register file drives rf_wready.
interface alu_writeback_if #(
  parameter int DW  = 8,
  parameter int AW  = 3,
  parameter int PCW = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_sel;
  logic [AW-1:0]  in_rd;
  logic [DW-1:0]  in_f;
  logic           in_ovf;
  logic           in_take_branch;
  logic [PCW-1:0] in_br_target;
  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic           rf_wready;

  modport master (
    output in_valid, in_sel, in_rd, in_f, in_ovf, in_take_branch, in_br_target,
    input  in_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rf_wready
  );

  modport slave (
    input  in_valid, in_sel, in_rd, in_f, in_ovf, in_take_branch, in_br_target,
    output in_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rf_wready
  );
endinterface

// File: rtl/alu_writeback.sv
// Commit stage after the ALU: one-deep register-file write buffer, committed PC,
// wrong-path squash after taken branches and overflow status/counter.
module alu_writeback #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int PCW      = 8,
  parameter int SQUASH_N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave bus,
  output logic [PCW-1:0] pc,
  output logic           flush,
  output logic           ovf_sticky,
  output logic [7:0]     ovf_count,
  input  logic           clr_ovf
);

  logic [2:0] squash_cnt;
  logic       acc;
  logic       live;
  logic       dropped;
  logic       is_branch;
  logic       wr_load;
  logic       taken;
  logic       ovf_evt;

  // The buffer drains and reloads on the same edge, so ready only drops on a stalled write.
  assign bus.in_ready = ~bus.rf_we | bus.rf_wready;

  assign acc       = bus.in_valid & bus.in_ready;
  assign live      = acc & (squash_cnt == 3'd0);
  assign dropped   = acc & (squash_cnt != 3'd0);
  assign is_branch = (bus.in_sel == 3'd6) | (bus.in_sel == 3'd7);
  assign wr_load   = live & ~is_branch & (bus.in_rd != '0);
  assign taken     = live & is_branch & bus.in_take_branch;
  assign ovf_evt   = live & (bus.in_sel == 3'd0) & bus.in_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else if (wr_load) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.in_rd;
      bus.rf_wdata <= bus.in_f;
    end else if (bus.rf_wready) begin
      bus.rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      flush      <= 1'b0;
      squash_cnt <= 3'd0;
    end else begin
      flush <= taken;
      if (live) begin
        pc <= taken ? bus.in_br_target : pc + PCW'(1);
      end
      // A branch arriving while squashing is itself dropped and never reloads the counter.
      if (taken) begin
        squash_cnt <= 3'(SQUASH_N);
      end else if (dropped) begin
        squash_cnt <= squash_cnt - 3'd1;
      end
    end
  end

  // A counted overflow wins over a coincident clear: the count restarts at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end else if (ovf_evt) begin
      ovf_sticky <= 1'b1;
      if (clr_ovf) begin
        ovf_count <= 8'd1;
      end else if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= 8'd0;
    end
  end

endmodule
